// File: rtl/frog_motion_control.sv
// Frog motion control: tile-stepped movement, auto-repeat, score,
// crossing pulse and collision respawn for the frogger playfield.
module frog_motion_control #(
    parameter int TILE_SIZE         = 32,
    parameter int H_VISIBLE_AREA    = 640,
    parameter int V_VISIBLE_AREA    = 480,
    parameter int C_X_BASE_POSITION = 320,
    parameter int C_Y_BASE_POSITION = 448,
    parameter int C_SCORE_INI       = 0,
    parameter int C_SCORE_MAX       = 9,
    parameter int COUNT_LIMIT       = 12500000,
    parameter int RESPAWN_CYCLES    = 25000000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Frog_Up,
    input  logic       i_Frog_Dn,
    input  logic       i_Frog_Lt,
    input  logic       i_Frog_Rt,
    input  logic       i_Game_Active,
    input  logic       i_Has_Collided,
    output logic [9:0] o_Frog_X,
    output logic [8:0] o_Frog_Y,
    output logic [3:0] o_Score,
    output logic       o_Level_Up
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READY,
        S_REPEAT,
        S_RESPAWN
    } state_t;

    localparam int RPT_W = $clog2(COUNT_LIMIT + 1);
    localparam int RSP_W = $clog2(RESPAWN_CYCLES + 1);

    localparam logic [9:0] X_BASE = 10'(C_X_BASE_POSITION);
    localparam logic [8:0] Y_BASE = 9'(C_Y_BASE_POSITION);
    localparam logic [9:0] X_TILE = 10'(TILE_SIZE);
    localparam logic [8:0] Y_TILE = 9'(TILE_SIZE);
    localparam logic [9:0] X_LAST = 10'(H_VISIBLE_AREA - TILE_SIZE);
    localparam logic [8:0] Y_LAST = 9'(V_VISIBLE_AREA - TILE_SIZE);
    localparam logic [3:0] SC_INI = 4'(C_SCORE_INI);
    localparam logic [3:0] SC_MAX = 4'(C_SCORE_MAX);

    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(COUNT_LIMIT - 1);
    localparam logic [RSP_W-1:0] RSP_LAST = RSP_W'(RESPAWN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic [3:0]       score_q, score_d;
    logic             lvl_q, lvl_d;
    logic [3:0]       dir_q, dir_d;
    logic [3:0]       sw_prev_q;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [RSP_W-1:0] rsp_q, rsp_d;

    logic [3:0] sw;
    logic [3:0] sw_rise;
    logic [3:0] win;
    logic [3:0] step_dir;
    logic       held;
    logic       rpt_fire;
    logic       take;
    logic       crossing;
    logic [9:0] step_x;
    logic [8:0] step_y;

    // Direction vectors are one-hot {up, dn, lt, rt}.
    assign sw       = {i_Frog_Up, i_Frog_Dn, i_Frog_Lt, i_Frog_Rt};
    assign sw_rise  = sw & ~sw_prev_q;
    assign held     = |(sw & dir_q);
    assign rpt_fire = (state_q == S_REPEAT) && (rpt_q == RPT_LAST);

    always_comb begin
        win = '0;
        if (!(&sw)) begin
            priority case (1'b1)
                sw_rise[3]: win = 4'b1000;
                sw_rise[2]: win = 4'b0100;
                sw_rise[1]: win = 4'b0010;
                sw_rise[0]: win = 4'b0001;
                default:    win = '0;
            endcase
        end
    end

    assign step_dir = (state_q == S_READY)   ? win   :
                      (rpt_fire && held)     ? dir_q : '0;

    // Blocked steps leave the position alone; up from row 0 is a crossing.
    always_comb begin
        step_x   = x_q;
        step_y   = y_q;
        crossing = 1'b0;
        priority case (1'b1)
            step_dir[3]: begin
                if (y_q == '0) crossing = 1'b1;
                else           step_y = y_q - Y_TILE;
            end
            step_dir[2]: begin
                if (y_q < Y_LAST) step_y = y_q + Y_TILE;
            end
            step_dir[1]: begin
                if (x_q != '0) step_x = x_q - X_TILE;
            end
            step_dir[0]: begin
                if (x_q < X_LAST) step_x = x_q + X_TILE;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        score_d = score_q;
        lvl_d   = 1'b0;
        dir_d   = dir_q;
        rpt_d   = rpt_q;
        rsp_d   = rsp_q;
        take    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_READY;
                score_d = SC_INI;
                x_d     = X_BASE;
                y_d     = Y_BASE;
            end
            S_READY: begin
                if (i_Has_Collided) begin
                    state_d = S_RESPAWN;
                    x_d     = X_BASE;
                    y_d     = Y_BASE;
                    rsp_d   = '0;
                end else if (|win) begin
                    take    = 1'b1;
                    state_d = S_REPEAT;
                    dir_d   = win;
                    rpt_d   = '0;
                end
            end
            S_REPEAT: begin
                if (i_Has_Collided) begin
                    state_d = S_RESPAWN;
                    x_d     = X_BASE;
                    y_d     = Y_BASE;
                    rsp_d   = '0;
                    rpt_d   = '0;
                end else if (!held) begin
                    state_d = S_READY;
                    rpt_d   = '0;
                end else if (rpt_fire) begin
                    take  = 1'b1;
                    rpt_d = '0;
                end else begin
                    rpt_d = rpt_q + RPT_W'(1);
                end
            end
            S_RESPAWN: begin
                if (rsp_q == RSP_LAST) begin
                    state_d = S_READY;
                    rsp_d   = '0;
                end else begin
                    rsp_d = rsp_q + RSP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            if (crossing) begin
                x_d     = X_BASE;
                y_d     = Y_BASE;
                lvl_d   = 1'b1;
                score_d = (score_q == SC_MAX) ? 4'd0 : score_q + 4'd1;
                state_d = S_READY;
                rpt_d   = '0;
            end else begin
                x_d = step_x;
                y_d = step_y;
            end
        end

        // Game inactive overrides everything but reset; score stays shown.
        if (!i_Game_Active) begin
            state_d = S_IDLE;
            x_d     = X_BASE;
            y_d     = Y_BASE;
            score_d = score_q;
            lvl_d   = 1'b0;
            rpt_d   = '0;
            rsp_d   = '0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            x_q       <= X_BASE;
            y_q       <= Y_BASE;
            score_q   <= SC_INI;
            lvl_q     <= 1'b0;
            dir_q     <= '0;
            sw_prev_q <= '0;
            rpt_q     <= '0;
            rsp_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            score_q   <= score_d;
            lvl_q     <= lvl_d;
            dir_q     <= dir_d;
            sw_prev_q <= sw;
            rpt_q     <= rpt_d;
            rsp_q     <= rsp_d;
        end
    end

    assign o_Frog_X   = x_q;
    assign o_Frog_Y   = y_q;
    assign o_Score    = score_q;
    assign o_Level_Up = lvl_q;

endmodule

// File: doc/frog_motion_control.md
Name: frog_motion_control

Overview:
- Converts the four debounced switch levels into tile-stepped frog moves on the 640x480 playfield.
- Owns frog position, score and the level-up pulse, and handles collision respawn with a short invulnerability window.
- Sits directly downstream of the debounce filters and the game-flow state machine (consumes its game-active flag).
- Feeds the frog position to sprite display and collision detection, score to the seven-segment display, and the level-up pulse to the car-direction reseed logic.

Parameters:
- TILE_SIZE, 32: step size in pixels; positions are always multiples of it.
- H_VISIBLE_AREA, 640: horizontal playfield width in pixels.
- V_VISIBLE_AREA, 480: vertical playfield height in pixels.
- C_X_BASE_POSITION, 320: spawn X in pixels.
- C_Y_BASE_POSITION, 448: spawn Y in pixels (bottom row).
- C_SCORE_INI, 0: score at reset and at game start.
- C_SCORE_MAX, 9: last score value before wrap.
- COUNT_LIMIT, 12500000: held-switch auto-repeat period in clocks.
- RESPAWN_CYCLES, 25000000: post-collision lockout in clocks.

Ports:
- i_Clk  in  1  system clock (25 MHz pixel clock).
- i_Reset  in  1  synchronous, active-high reset.
- i_Frog_Up  in  1  debounced up switch, level.
- i_Frog_Dn  in  1  debounced down switch, level.
- i_Frog_Lt  in  1  debounced left switch, level.
- i_Frog_Rt  in  1  debounced right switch, level.
- i_Game_Active  in  1  high while the game is running.
- i_Has_Collided  in  1  frog/car overlap, level.
- o_Frog_X  out  10  frog left edge, in pixels.
- o_Frog_Y  out  9  frog top edge, in pixels.
- o_Score  out  4  completed crossings.
- o_Level_Up  out  1  one-clock pulse when a crossing completes.

Behaviour:
- Reset (i_Reset=1 at posedge):
  - X=C_X_BASE_POSITION, Y=C_Y_BASE_POSITION, score=C_SCORE_INI, o_Level_Up=0.
  - State=IDLE; repeat and respawn counters cleared; switch-history registers cleared.
  - Reset wins over every other input, including mid-respawn and mid-repeat.
- States:
  - IDLE: frog held at base; no moves.
    - i_Game_Active rising -> READY, with score<=C_SCORE_INI that same cycle.
  - READY: accepts moves. A move occurs on the clock after a switch rising edge (edge = level 1, previous sample 0).
    - Winner on the same cycle: Up > Dn > Lt > Rt.
    - All four high together -> no move (this is the start gesture).
  - REPEAT: entered when the winning switch stays held.
    - Counter counts to COUNT_LIMIT-1, then issues another step of the same direction and restarts.
    - Release of that switch -> READY; counter cleared.
  - RESPAWN: entered on i_Has_Collided=1 in READY/REPEAT.
    - Next clock: X/Y<=base. Score unchanged.
    - Switches and i_Has_Collided ignored for RESPAWN_CYCLES clocks, then -> READY.
    - Switch-history registers keep sampling, so a switch held through RESPAWN does not move the frog on exit.
- i_Game_Active=0 in any state:
  - -> IDLE next clock; position forced to base; score held for display.
- Same-cycle priority: reset > game inactive > collision > move.
- Step arithmetic:
  - Up: Y-TILE_SIZE. Dn: Y+TILE_SIZE. Lt: X-TILE_SIZE. Rt: X+TILE_SIZE.
  - No wrap or underflow: left at X=0, right at X=H_VISIBLE_AREA-TILE_SIZE, and down at Y=V_VISIBLE_AREA-TILE_SIZE are ignored; position unchanged.
  - Up at Y=0 is a crossing:
    - o_Level_Up=1 for exactly one clock; X/Y<=base.
    - Score +1, with C_SCORE_MAX+1 wrapping to 0.
    - State returns to READY; any repeat in progress is cancelled.
- Latency:
  - Switch edge to new position: 1 clock.
  - Collision to base position: 1 clock.
  - Level-up pulse is coincident with the base reload.
- Outputs are registered; no combinational input-to-output paths.

Test Plan (TILE_SIZE=32, COUNT_LIMIT=8, RESPAWN_CYCLES=4):
1. Reset, then raise i_Game_Active -> X=320, Y=448, score=0. Pulse Up -> Y=416 one clock after the edge. Left twice -> X=256.
2. Hold Up for 20 clocks from Y=448 -> Y=416 at edge+1, 384 at edge+9, 352 at edge+17; release -> no further change.
3. Place the frog at X=0 and press Left -> X stays 0. At Y=448 press Down -> Y stays 448. Up+Rt on the same clock -> only Y changes. All four on the same clock -> no change.
4. Step Up 14 times from 448, then once more from Y=0 -> o_Level_Up high for exactly 1 clock, X/Y=320/448, score=1. Repeat from score=9 -> score=0.
5. i_Has_Collided with Up edge in the same cycle at Y=352 -> X/Y=320/448, no step. Switch edges and collisions during the next 4 clocks are ignored; an Up edge after them -> Y=416.
6. Assert i_Reset during RESPAWN and during REPEAT -> all outputs at reset values next clock. Drop i_Game_Active -> frog to base, score held. Re-raise -> score=0.
